lights_multi_divider: RTL and testbench
=======================================

Name: lights_multi_divider

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio lights clock divider.
- Each channel produces a toggled square-wave output and a one-cycle tick strobe from the system clock.
- Each channel's divide value and enable are reprogrammable at runtime through a valid/ready config port.
- New settings are applied glitch-free at the channel's terminal count.
- Feeds LED pattern / blink logic that needs several independent rates.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, counter and divide-value width in bits.
- DEFAULT_DIV, 25000000, divide value loaded into every channel at reset (must fit in CNT_W).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write can be accepted; equals ~pending[cfg_ch].
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
- cfg_div  input  CNT_W  new divide value.
- cfg_en  input  1  new channel enable.
- div_clk  output  NUM_CH  per-channel square-wave output.
- tick  output  NUM_CH  per-channel one-cycle strobe at terminal count.
- pending  output  NUM_CH  per-channel flag: accepted config not yet applied.

Behaviour:
- Reset (rst_n low at posedge clk):
  - All counters = 0; div_clk = 0; tick = 0; pending = 0.
  - Active div = DEFAULT_DIV; active en = 1.
  - Out of reset every channel runs at DEFAULT_DIV.
- Counting, per channel, while active en = 1:
  - Counter runs 0..div.
  - Terminal count (TC) is the cycle where counter == div.
  - At TC: counter returns to 0, div_clk toggles, tick = 1 for exactly that one cycle (registered, asserted the cycle after counter == div is sampled).
  - Tick period = div+1 cycles; div_clk period = 2*(div+1) cycles, 50% duty.
  - div = 0: tick high every cycle; div_clk toggles every cycle.
- Disabled channel (active en = 0): counter held at 0; div_clk = 0; tick = 0.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready at posedge clk.
  - cfg_div and cfg_en are captured into that channel's shadow register, and pending[ch] is set.
  - Writes to a channel with pending set are stalled (cfg_ready = 0); no write is ever dropped or overwritten.
  - cfg_ch >= NUM_CH: cfg_ready = 1, the write is accepted and discarded, no state changes.
- Apply rules:
  - Channel enabled: shadow is applied on that channel's next TC edge. That TC completes normally under the old config (tick pulses, div_clk toggles). The counter restarts at 0 under the new div, and pending clears on the same edge.
    - If the new en = 0: div_clk is forced to 0 on that edge instead of toggling; tick still pulses once.
  - Channel disabled: shadow is applied on the edge after acceptance (1-cycle latency) and pending clears. The counter starts from 0 with div_clk = 0.
  - Acceptance and TC on the same edge: the new config is not applied until the following TC (or the next edge if disabled).
- Active div is never compared against a half-written value; only shadow → active transfers change the period.
- Reset mid-operation: all shadows and pending are discarded and the reset values are restored.
- Channels are fully independent; simultaneous TCs on multiple channels are legal.

Optional Feature:
- Macro: LIGHTS_SYNC_EN.
- Defined:
  - Adds input sync_restart (1 bit).
  - When sampled high, every channel's counter = 0 and div_clk = 0 on that edge, and tick = 0.
  - All pending shadows are applied on that same edge and pending clears; enabled channels then run phase-aligned.
  - sync_restart has lower priority than rst_n and higher priority than TC and the config apply rules.
- Undefined: the port is absent and channels are aligned only by reset.

Test Plan:
- Reset with DEFAULT_DIV=3, NUM_CH=2 → tick on each channel every 4 cycles; div_clk period 8 cycles, 4 high / 4 low.
- Write ch1 div=1 en=1 mid-period → pending[1]=1, cfg_ready low for ch1 until ch1 TC. Old period completes, then tick every 2 cycles; ch0 is unaffected.
- Write ch0 div=0 → after TC, tick[0] constant 1 and div_clk[0] toggles every cycle.
- Write ch0 en=0, then en=1 div=2 → div_clk[0] = 0 after the TC, tick stops. Second write applied 1 cycle after acceptance; first tick 3 cycles later.
- Write with cfg_ch=3 when NUM_CH=2 → cfg_ready=1, no output or pending change. Assert rst_n low while pending[0]=1 → pending=0, div back to DEFAULT_DIV.
- (LIGHTS_SYNC_EN) ch0 div=2, ch1 div=5, pulse sync_restart → both div_clk = 0 and counters = 0 next edge. Ticks coincide every 6 cycles (ch1 TC aligned with every second ch0 TC).

Source files
------------

// File: rtl/lights_multi_divider.sv
// Multi-channel programmable divider: per-channel square wave and tick strobe, config shadowed and applied at TC.
// Optional build macro LIGHTS_SYNC_EN adds sync_restart, which phase-aligns every channel.
module lights_multi_divider #(
   parameter int unsigned  NUM_CH      = 4,
   parameter int unsigned  CNT_W       = 26,
   parameter int unsigned  DEFAULT_DIV = 25000000,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef LIGHTS_SYNC_EN
   input  logic              sync_restart,
`endif
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_en,
   output logic [NUM_CH-1:0] div_clk,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending
);

   typedef struct packed {
      logic [CNT_W-1:0] div;
      logic             en;
   } ch_cfg_t;

   ch_cfg_t           active [NUM_CH];
   ch_cfg_t           shadow [NUM_CH];
   logic [CNT_W-1:0]  cnt    [NUM_CH];
   logic [NUM_CH-1:0] wr_hit;
   ch_cfg_t           cfg_word;
   logic              restart;

   assign cfg_word = '{div: cfg_div, en: cfg_en};

`ifdef LIGHTS_SYNC_EN
   assign restart = sync_restart;
`else
   assign restart = 1'b0;
`endif

   // Channel decode; an out-of-range index matches nothing, so it is ready and silently dropped.
   always_comb begin
      cfg_ready = 1'b1;
      wr_hit    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = ~pending[i];
            wr_hit[i] = cfg_valid & ~pending[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            active[i] <= '{div: CNT_W'(DEFAULT_DIV), en: 1'b1};
            shadow[i] <= '0;
         end
         div_clk <= '0;
         tick    <= '0;
         pending <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (restart) begin
               cnt[i]     <= '0;
               div_clk[i] <= 1'b0;
               tick[i]    <= 1'b0;
               if (pending[i]) begin
                  active[i]  <= shadow[i];
                  pending[i] <= 1'b0;
               end
            end else if (!active[i].en) begin
               cnt[i]     <= '0;
               div_clk[i] <= 1'b0;
               tick[i]    <= 1'b0;
               if (pending[i]) begin
                  active[i]  <= shadow[i];
                  pending[i] <= 1'b0;
               end
            end else if (cnt[i] == active[i].div) begin
               // Terminal count: finish this period under the old setting, then swap in the shadow.
               cnt[i]  <= '0;
               tick[i] <= 1'b1;
               if (pending[i]) begin
                  active[i]  <= shadow[i];
                  pending[i] <= 1'b0;
                  div_clk[i] <= shadow[i].en ? ~div_clk[i] : 1'b0;
               end else begin
                  div_clk[i] <= ~div_clk[i];
               end
            end else begin
               cnt[i]  <= cnt[i] + CNT_W'(1);
               tick[i] <= 1'b0;
            end

            // Acceptance only happens with pending clear, so it never collides with an apply above.
            if (wr_hit[i]) begin
               shadow[i]  <= cfg_word;
               pending[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lights_multi_divider.sv
// Directed self-checking bench for lights_multi_divider (3 channels, default divide 3).
module tb_lights_multi_divider;

   localparam int unsigned NUM_CH  = 3;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned DEF_DIV = 3;
   localparam int unsigned CH_W    = 2;

   logic              clk;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_en;
   logic [NUM_CH-1:0] div_clk;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] pending;
`ifdef LIGHTS_SYNC_EN
   logic              sync_restart;
`endif

   int n_checks;
   int n_fail;
   int n;
   int t0, t1, h0, h1, both;

   lights_multi_divider #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef LIGHTS_SYNC_EN
      .sync_restart (sync_restart),
`endif
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ch       (cfg_ch),
      .cfg_div      (cfg_div),
      .cfg_en       (cfg_en),
      .div_clk      (div_clk),
      .tick         (tick),
      .pending      (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int ch, input int div, input bit en);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = CNT_W'(div);
      cfg_en    = en;
      #1;
      check("cfg_ready before write", 32'(cfg_ready), 1);
      step();
      cfg_valid = 1'b0;
   endtask

   // Steps until tick[ch] is seen; n = cycles taken, or -1 if the budget runs out.
   task automatic wait_tick(input int ch, input int budget, output int cycles);
      cycles = -1;
      for (int k = 1; k <= budget; k++) begin
         step();
         if (tick[ch]) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic wait_clear(input int ch, input int budget, output int cycles);
      cycles = -1;
      for (int k = 1; k <= budget; k++) begin
         step();
         if (!pending[ch]) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic observe(input int cycles, output int tk0, output int tk1,
                          output int hi0, output int hi1, output int tboth);
      tk0 = 0; tk1 = 0; hi0 = 0; hi1 = 0; tboth = 0;
      for (int k = 0; k < cycles; k++) begin
         step();
         tk0   += int'(tick[0]);
         tk1   += int'(tick[1]);
         hi0   += int'(div_clk[0]);
         hi1   += int'(div_clk[1]);
         tboth += int'(tick[0] & tick[1]);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_en    = 1'b0;
`ifdef LIGHTS_SYNC_EN
      sync_restart = 1'b0;
`endif
      step(); step(); step();

      // Reset state
      check("reset tick", 32'(tick), 0);
      check("reset div_clk", 32'(div_clk), 0);
      check("reset pending", 32'(pending), 0);
      check("reset cfg_ready", 32'(cfg_ready), 1);

      // Default divide of 3: tick every 4, div_clk 4 high / 4 low
      rst_n = 1'b1;
      wait_tick(0, 10, n);
      check("first tick latency", 32'(n), 4);
      check("all channels tick together", 32'(tick), 3'b111);
      check("div_clk high after first TC", 32'(div_clk), 3'b111);
      observe(8, t0, t1, h0, h1, both);
      check("default ticks ch0", 32'(t0), 2);
      check("default ticks ch1", 32'(t1), 2);
      check("default div_clk high ch0", 32'(h0), 4);
      check("default div_clk high ch1", 32'(h1), 4);

      // ch1 -> div 1 mid-period; applied at its next TC
      step();
      write(1, 1, 1'b1);
      check("pending after ch1 write", 32'(pending), 3'b010);
      check("ch1 stalled while pending", 32'(cfg_ready), 0);
      wait_tick(1, 10, n);
      check("ch1 old period completes", 32'(n), 2);
      check("ch1 pending clears at TC", 32'(pending), 0);
      check("ch0 ticks same edge", 32'(tick[0]), 1);
      observe(8, t0, t1, h0, h1, both);
      check("ch0 unaffected ticks", 32'(t0), 2);
      check("ch1 div1 ticks", 32'(t1), 4);
      check("ch1 div1 div_clk high", 32'(h1), 4);

      // ch0 -> div 0: tick every cycle
      write(0, 0, 1'b1);
      check("pending after ch0 div0 write", 32'(pending[0]), 1);
      wait_tick(0, 10, n);
      check("ch0 div0 applied at TC", 32'(n), 3);
      check("ch0 pending clears", 32'(pending[0]), 0);
      observe(6, t0, t1, h0, h1, both);
      check("ch0 div0 ticks", 32'(t0), 6);
      check("ch0 div0 div_clk high", 32'(h0), 3);

      // ch0 disable: last tick pulses, div_clk forced low
      write(0, 5, 1'b0);
      check("pending after disable write", 32'(pending[0]), 1);
      step();
      check("disable edge tick", 32'(tick[0]), 1);
      check("disable edge div_clk", 32'(div_clk[0]), 0);
      check("disable edge pending", 32'(pending[0]), 0);
      observe(5, t0, t1, h0, h1, both);
      check("disabled ch0 ticks", 32'(t0), 0);
      check("disabled ch0 div_clk high", 32'(h0), 0);

      // Re-enable with div 2 while disabled: applied one edge after acceptance
      write(0, 2, 1'b1);
      check("pending after enable write", 32'(pending[0]), 1);
      step();
      check("enable applied next edge", 32'(pending[0]), 0);
      check("enable edge tick", 32'(tick[0]), 0);
      check("enable edge div_clk", 32'(div_clk[0]), 0);
      wait_tick(0, 10, n);
      check("first tick after enable", 32'(n), 3);
      check("div_clk rises at first TC", 32'(div_clk[0]), 1);

      // Out-of-range channel: accepted and dropped
      write(3, 7, 1'b0);
      check("out-of-range no pending", 32'(pending), 0);
      wait_tick(2, 10, n);
      wait_tick(2, 10, n);
      check("ch2 still default period", 32'(n), 4);

      // Reset while a write is pending
      write(0, 9, 1'b1);
      check("pending before reset", 32'(pending[0]), 1);
      rst_n = 1'b0;
      step();
      check("reset clears pending", 32'(pending), 0);
      check("reset clears tick", 32'(tick), 0);
      check("reset clears div_clk", 32'(div_clk), 0);
      rst_n = 1'b1;
      wait_tick(0, 10, n);
      check("post-reset first tick", 32'(n), 4);
      check("post-reset aligned", 32'(tick), 3'b111);
      wait_tick(0, 10, n);
      check("post-reset default period", 32'(n), 4);

`ifdef LIGHTS_SYNC_EN
      // Sync restart aligns ch0 (div 2) with ch1 (div 5, applied by the restart itself)
      write(0, 2, 1'b1);
      wait_clear(0, 10, n);
      check("ch0 div2 applied", 32'(n > 0), 1);
      write(1, 5, 1'b1);
      sync_restart = 1'b1;
      step();
      sync_restart = 1'b0;
      check("sync clears pending", 32'(pending), 0);
      check("sync div_clk low", 32'(div_clk), 0);
      check("sync tick low", 32'(tick), 0);
      observe(12, t0, t1, h0, h1, both);
      check("sync ch0 ticks", 32'(t0), 4);
      check("sync ch1 ticks", 32'(t1), 2);
      check("sync coincident ticks", 32'(both), 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
